// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end sharing one registered signed_adder.
// Optional per-requester sticky overflow flags enabled by ADDER_ARB_OVF_STICKY_EN.

// Carry-extended adder; overflow flags a carry out of the SIZE-bit operands.
module signed_adder #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   sum,
  output logic            overflow
);
  assign sum      = {1'b0, a} + {1'b0, b};
  assign overflow = sum[SIZE];
endmodule

module adder_arbiter #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [SIZE-1:0] req_a0,
  input  logic [SIZE-1:0] req_b0,
  input  logic [SIZE-1:0] req_a1,
  input  logic [SIZE-1:0] req_b1,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_id,
  output logic [SIZE:0]   res_sum,
  output logic            res_overflow
`ifdef ADDER_ARB_OVF_STICKY_EN
  ,
  input  logic            ovf_clear,
  output logic [1:0]      ovf_sticky
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state;
  logic [SIZE-1:0] op_a;
  logic [SIZE-1:0] op_b;
  logic            op_id;
  logic            last_grant;
  logic            grant_id;
  logic [SIZE:0]   add_sum;
  logic            add_ovf;

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (!rst && state == IDLE && |req_valid)
      req_ready = grant_id ? 2'b10 : 2'b01;
  end

  signed_adder #(.SIZE(SIZE)) u_adder (
    .a        (op_a),
    .b        (op_b),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= 1'b0;
      last_grant   <= 1'b1;
      res_valid    <= 1'b0;
      res_sum      <= '0;
      res_overflow <= 1'b0;
      res_id       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            op_a       <= grant_id ? req_a1 : req_a0;
            op_b       <= grant_id ? req_b1 : req_b0;
            op_id      <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_sum      <= add_sum;
          res_overflow <= add_ovf;
          res_id       <= op_id;
          res_valid    <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_OVF_STICKY_EN
  logic [1:0] ovf_set;

  // A set in the same cycle as a clear takes priority.
  always_comb begin
    ovf_set = 2'b00;
    if (res_valid && res_ready && res_overflow)
      ovf_set = res_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_sticky <= 2'b00;
    else
      ovf_sticky <= ovf_set | (ovf_sticky & ~{2{ovf_clear}});
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter at SIZE=2; sticky checks run when ADDER_ARB_OVF_STICKY_EN is defined.
`timescale 1ns/1ps
module tb_adder_arbiter;

  localparam int unsigned SIZE = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [SIZE-1:0] req_a0 = '0;
  logic [SIZE-1:0] req_b0 = '0;
  logic [SIZE-1:0] req_a1 = '0;
  logic [SIZE-1:0] req_b1 = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic            res_id;
  logic [SIZE:0]   res_sum;
  logic            res_overflow;
`ifdef ADDER_ARB_OVF_STICKY_EN
  logic            ovf_clear = 1'b0;
  logic [1:0]      ovf_sticky;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a0       (req_a0),
    .req_b0       (req_b0),
    .req_a1       (req_a1),
    .req_b1       (req_b1),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_id       (res_id),
    .res_sum      (res_sum),
    .res_overflow (res_overflow)
`ifdef ADDER_ARB_OVF_STICKY_EN
    ,
    .ovf_clear    (ovf_clear),
    .ovf_sticky   (ovf_sticky)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    #1;
    check("ready_in_rst", 32'(req_ready), 32'h0);
    step();
    rst       = 1'b0;
    req_valid = 2'b00;
  endtask

  // Complete one transaction with res_ready high; starts and ends in IDLE.
  task automatic run_one(input string tag, input logic [1:0] exp_ready, input logic exp_id,
                         input logic [2:0] exp_sum, input logic exp_ovf);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
    step();
    step();
    check({tag, "_valid"}, 32'(res_valid), 32'h1);
    check({tag, "_id"}, 32'(res_id), 32'(exp_id));
    check({tag, "_sum"}, 32'(res_sum), 32'(exp_sum));
    check({tag, "_ovf"}, 32'(res_overflow), 32'(exp_ovf));
    step();
    check({tag, "_done"}, 32'(res_valid), 32'h0);
  endtask

  initial begin
    step();
    do_reset();
    check("rst_valid", 32'(res_valid), 32'h0);
    check("rst_sum", 32'(res_sum), 32'h0);
    check("rst_ovf", 32'(res_overflow), 32'h0);
    check("rst_id", 32'(res_id), 32'h0);

    // Single request; operands change after acceptance.
    req_valid = 2'b01; req_a0 = 2'b10; req_b0 = 2'b01; res_ready = 1'b1;
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 2'b00; req_a0 = 2'b00; req_b0 = 2'b00;
    check("t1_exec_valid", 32'(res_valid), 32'h0);
    check("t1_exec_ready", 32'(req_ready), 32'h0);
    step();
    check("t1_valid", 32'(res_valid), 32'h1);
    check("t1_sum", 32'(res_sum), 32'h3);
    check("t1_ovf", 32'(res_overflow), 32'h0);
    check("t1_id", 32'(res_id), 32'h0);
    step();
    check("t1_done", 32'(res_valid), 32'h0);

    // Round robin with both requesters held valid from reset.
    do_reset();
    req_valid = 2'b11; res_ready = 1'b1;
    req_a0 = 2'b10; req_b0 = 2'b10; req_a1 = 2'b11; req_b1 = 2'b01;
    run_one("rr0", 2'b01, 1'b0, 3'b100, 1'b1);
    run_one("rr1", 2'b10, 1'b1, 3'b100, 1'b1);
    run_one("rr2", 2'b01, 1'b0, 3'b100, 1'b1);
    run_one("rr3", 2'b10, 1'b1, 3'b100, 1'b1);

    // Backpressure in HOLD for 5 cycles.
    req_valid = 2'b01; req_a0 = 2'b01; req_b0 = 2'b01; res_ready = 1'b0;
    #1;
    check("hold_accept", 32'(req_ready), 32'h1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(res_valid), 32'h1);
      check("hold_sum", 32'(res_sum), 32'h2);
      check("hold_id", 32'(res_id), 32'h0);
      check("hold_ready", 32'(req_ready), 32'h0);
      step();
    end
    res_ready = 1'b1; req_valid = 2'b00;
    step();
    check("hold_release", 32'(res_valid), 32'h0);
    req_valid = 2'b01;
    #1;
    check("hold_idle", 32'(req_ready), 32'h1);

    // Reset during EXEC discards the operation and restores the tie winner.
    step();
    rst = 1'b1;
    #1;
    check("exec_rst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0; req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check("exec_rst_valid", 32'(res_valid), 32'h0);
      step();
    end
    req_valid = 2'b11;
    run_one("post_rst", 2'b01, 1'b0, 3'b010, 1'b0);

`ifdef ADDER_ARB_OVF_STICKY_EN
    req_valid = 2'b10; req_a1 = 2'b11; req_b1 = 2'b01; ovf_clear = 1'b1;
    #1;
    check("sticky_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 2'b00;
    step();
    check("sticky_pre", 32'(ovf_sticky), 32'h0);
    step();
    check("sticky_set", 32'(ovf_sticky), 32'h2);
    step();
    check("sticky_clear", 32'(ovf_sticky), 32'h0);
    ovf_clear = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 8, operand width in bits passed to the shared signed_adder instance.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-005 SHALL have req_ready  output  2  per-requester accept strobe; at most one bit high.
REQ-006 SHALL have req_a0, req_b0, req_a1, req_b1  input  SIZE each  operands of requesters 0 and 1.
REQ-007 SHALL have res_valid  output  1  result available.
REQ-008 SHALL have res_ready  input  1  consumer accepts result.
REQ-009 SHALL have res_id  output  1  requester that owns the current result.
REQ-010 SHALL have res_sum  output  SIZE+1  registered result output of the shared signed_adder.
REQ-011 SHALL have res_overflow  output  1  registered overflow output of the shared signed_adder.

Function
REQ-012 SHALL instantiate exactly one signed_adder with parameter SIZE, fed only from internal operand registers op_a/op_b.
REQ-013 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-014 IDLE: req_ready = grant vector (combinational); when any req_valid high, load granted operands into op_a/op_b, latch id, go to EXEC; otherwise stay in IDLE.
REQ-015 req_ready SHALL be 0 in EXEC and HOLD; a transfer occurs only when req_valid[i] and req_ready[i] are both high.
REQ-016 EXEC: register adder result into res_sum/res_overflow, id into res_id, set res_valid, go to HOLD (one cycle, unconditional).
REQ-017 HOLD: res_valid, res_sum, res_overflow, res_id held stable; on res_ready high, clear res_valid at the edge and go to IDLE.
REQ-018 Latency: request accepted at edge N, res_valid high after edge N+1; minimum spacing between accepts 3 cycles.
REQ-019 Arbitration: single valid requester is granted regardless of history; both valid grants the requester other than last_grant (round-robin).
REQ-020 last_grant SHALL update only on an accepted request.
REQ-021 Operand changes on req_a*/req_b* after acceptance SHALL NOT affect the in-flight result.
REQ-022 req_valid dropping in IDLE without acceptance SHALL leave last_grant and state unchanged.

Reset
REQ-023 On rst: state IDLE, res_valid 0, res_sum 0, res_overflow 0, res_id 0, op_a/op_b 0, last_grant 1 (requester 0 wins first tie).
REQ-024 rst asserted in EXEC or HOLD SHALL discard the in-flight operation; no res_valid pulse after release.
REQ-025 req_ready SHALL be 0 while rst is high.

Configuration
REQ-026 Macro ADDER_ARB_OVF_STICKY_EN SHALL, when defined, add ports ovf_clear (input, 1) and ovf_sticky (output, 2).
REQ-027 With the macro: ovf_sticky[i] sets when a result with res_overflow=1 and res_id=i is accepted (res_valid && res_ready); clears when ovf_clear high; simultaneous set and clear leaves it set; reset value 0.
REQ-028 Without the macro: ports absent, no sticky state, all other behaviour identical.

Verification (bench SIZE=2)
REQ-029 After reset, req_valid=01, a0=10, b0=01 -> req_ready=01 same cycle, res_valid after 2 edges, res_sum=011, res_overflow=0, res_id=0.
REQ-030 req_valid=11 held from reset, res_ready=1 -> grants alternate 0,1,0,1; a0=b0=10 gives res_sum=100 ovf=1; a1=11, b1=01 gives res_sum=100 ovf=1.
REQ-031 res_ready=0 for 5 cycles in HOLD -> res_valid, res_sum, res_id stable; req_ready=00 throughout; on res_ready=1 back to IDLE next edge.
REQ-032 rst pulsed during EXEC -> res_valid stays 0; next request with both valid is granted to requester 0.
REQ-033 With ADDER_ARB_OVF_STICKY_EN: accept overflowing requester-1 result with ovf_clear=1 in same cycle -> ovf_sticky=10; ovf_clear next cycle alone -> 00.
